aidc_lite_comp_zrle: RTL and testbench

//  Zero-run-length compressor for the AIDC-Lite path; the encoder counterpart of the ZRLE decompressor.
//  - Accepts one 64 B block as 8 beats of 64-bit data.
//  - Encodes each beat as a variable-length code selected by its zero/non-zero pattern of 16-bit lanes.
//  - Packs {PREFIX, codes, zero pad} MSB-first into 32-bit words with sop/eop; these words feed the decompressor input.
//  - Flags blocks whose code exceeds the decompressor code buffer as incompressible.

---
 rtl/aidc_lite_pkg.sv | 22 ++
 rtl/aidc_lite_zrle_enc_word.sv | 54 +++++
 rtl/aidc_lite_comp_zrle.sv | 120 ++++++++++++
 tb/tb_aidc_lite_comp_zrle.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aidc_lite_pkg.sv
// Shared constants and types for the AIDC-Lite zero-run-length compressor.
// Code lengths are full code widths (prefix + payload) in bits.
package aidc_lite_pkg;
  localparam int ZRLE_LEN_0N    = 6;
  localparam int ZRLE_LEN_1N_LO = 22;
  localparam int ZRLE_LEN_1N    = 21;
  localparam int ZRLE_LEN_2N    = 36;
  localparam int ZRLE_LEN_3N    = 52;
  localparam int ZRLE_LEN_4N    = 66;

  localparam logic [1:0] ZRLE_PREFIX = 2'b01;
  localparam int BLK_BEATS          = 8;
  localparam int CODE_BUF_SIZE_DFLT = 510;
  localparam int PACK_BITS          = 512;
  localparam int CODE_BITS          = 66;

  typedef enum logic [1:0] {
    ST_ENC,
    ST_EMIT,
    ST_FAIL
  } enc_state_e;
endpackage

// File: rtl/aidc_lite_zrle_enc_word.sv
// Combinational ZRLE encoder for one 64-bit beat: returns an MSB-aligned code
// (prefix followed by the non-zero lanes, lane 3 first) and its length.
module aidc_lite_zrle_enc_word
  import aidc_lite_pkg::*;
(
  input  logic [63:0] data,
  output logic [65:0] code,
  output logic [6:0]  len
);
  logic [3:0]  nz;
  logic [63:0] payload;
  logic [5:0]  pfx;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign nz[gi] = |data[16*gi +: 16];
    end
  endgenerate

  // Non-zero lanes shifted in from lane 3 down, so the payload ends up right-aligned.
  always_comb begin
    payload = '0;
    for (int l = 3; l >= 0; l--) begin
      if (nz[l]) payload = {payload[47:0], data[16*l +: 16]};
    end
  end

  // Prefix is left-aligned within 6 bits.
  always_comb begin
    pfx = 6'b000000;
    len = 7'(ZRLE_LEN_0N);
    case (nz)
      4'b0000: begin pfx = 6'b000000; len = 7'(ZRLE_LEN_0N);    end
      4'b0001: begin pfx = 6'b000001; len = 7'(ZRLE_LEN_1N_LO); end
      4'b0010: begin pfx = 6'b000010; len = 7'(ZRLE_LEN_1N);    end
      4'b0100: begin pfx = 6'b000100; len = 7'(ZRLE_LEN_1N);    end
      4'b1000: begin pfx = 6'b000110; len = 7'(ZRLE_LEN_1N);    end
      4'b0011: begin pfx = 6'b001000; len = 7'(ZRLE_LEN_2N);    end
      4'b0101: begin pfx = 6'b001100; len = 7'(ZRLE_LEN_2N);    end
      4'b1001: begin pfx = 6'b010000; len = 7'(ZRLE_LEN_2N);    end
      4'b0110: begin pfx = 6'b010100; len = 7'(ZRLE_LEN_2N);    end
      4'b1010: begin pfx = 6'b011000; len = 7'(ZRLE_LEN_2N);    end
      4'b1100: begin pfx = 6'b011100; len = 7'(ZRLE_LEN_2N);    end
      4'b0111: begin pfx = 6'b100000; len = 7'(ZRLE_LEN_3N);    end
      4'b1011: begin pfx = 6'b100100; len = 7'(ZRLE_LEN_3N);    end
      4'b1101: begin pfx = 6'b101000; len = 7'(ZRLE_LEN_3N);    end
      4'b1110: begin pfx = 6'b101100; len = 7'(ZRLE_LEN_3N);    end
      default: begin pfx = 6'b110000; len = 7'(ZRLE_LEN_4N);    end
    endcase
  end

  assign code = {pfx, 60'b0} | ({2'b00, payload} << (7'd66 - len));
endmodule

// File: rtl/aidc_lite_comp_zrle.sv
// ZRLE block compressor: packs PREFIX plus eight beat codes MSB-first into a
// 512-bit buffer, then streams it out as 32-bit words or flags the block as failed.
module aidc_lite_comp_zrle
  import aidc_lite_pkg::*;
#(
  parameter int CODE_BUF_SIZE = CODE_BUF_SIZE_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [63:0] data_i,
  output logic        valid_o,
  output logic        sop_o,
  output logic        eop_o,
  output logic [31:0] data_o,
  output logic        done_o,
  output logic        fail_o,
  output logic [4:0]  len_o
);
  localparam logic [9:0] BUF_LIMIT = 10'(CODE_BUF_SIZE);
  localparam logic [PACK_BITS-1:0] BUF_INIT = {ZRLE_PREFIX, {(PACK_BITS-2){1'b0}}};

  enc_state_e state_reg, state_next;

  logic [2:0]           beat_cnt_reg;
  logic [9:0]           bit_ptr_reg;
  logic [PACK_BITS-1:0] buf_reg;
  logic [4:0]           word_cnt_reg;
  logic [4:0]           nwords_reg;

  logic [65:0]          code;
  logic [6:0]           code_len;
  logic [9:0]           bit_ptr_sum;
  logic [10:0]          shamt;
  logic [PACK_BITS-1:0] code_placed;
  logic [4:0]           nwords_calc;
  logic                 accept, last_beat, last_word, over_limit, clear;

  aidc_lite_zrle_enc_word u_enc (
    .data (data_i),
    .code (code),
    .len  (code_len)
  );

  assign bit_ptr_sum = bit_ptr_reg + {3'b000, code_len};
  assign shamt       = {1'b0, bit_ptr_reg} + 11'd2;
  // Shifting right drops any code bits that would land past the buffer end.
  assign code_placed = {code, {(PACK_BITS-CODE_BITS){1'b0}}} >> shamt;
  // ceil((bit_ptr + 2) / 32)
  assign nwords_calc = 5'((bit_ptr_sum + 10'd33) >> 5);
  assign last_beat   = (beat_cnt_reg == 3'(BLK_BEATS-1));
  assign last_word   = (word_cnt_reg == nwords_reg - 5'd1);
  assign over_limit  = (bit_ptr_sum > BUF_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_ENC;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ready_o    = 1'b0;
    valid_o    = 1'b0;
    sop_o      = 1'b0;
    eop_o      = 1'b0;
    done_o     = 1'b0;
    fail_o     = 1'b0;
    len_o      = 5'd0;
    data_o     = 32'd0;
    accept     = 1'b0;
    clear      = 1'b0;
    case (state_reg)
      ST_ENC: begin
        ready_o = 1'b1;
        accept  = valid_i;
        if (valid_i && last_beat) state_next = over_limit ? ST_FAIL : ST_EMIT;
      end
      ST_EMIT: begin
        valid_o = 1'b1;
        data_o  = buf_reg[PACK_BITS-1 -: 32];
        sop_o   = (word_cnt_reg == 5'd0);
        if (last_word) begin
          eop_o      = 1'b1;
          done_o     = 1'b1;
          len_o      = nwords_reg;
          clear      = 1'b1;
          state_next = ST_ENC;
        end
      end
      ST_FAIL: begin
        done_o     = 1'b1;
        fail_o     = 1'b1;
        clear      = 1'b1;
        state_next = ST_ENC;
      end
      default: state_next = ST_ENC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      beat_cnt_reg <= 3'd0;
      bit_ptr_reg  <= 10'd0;
      buf_reg      <= BUF_INIT;
      word_cnt_reg <= 5'd0;
      nwords_reg   <= 5'd0;
    end else if (accept) begin
      buf_reg      <= buf_reg | code_placed;
      bit_ptr_reg  <= bit_ptr_sum;
      beat_cnt_reg <= beat_cnt_reg + 3'd1;
      word_cnt_reg <= 5'd0;
      if (last_beat) nwords_reg <= nwords_calc;
    end else if (state_reg == ST_EMIT) begin
      // Emit from the top of the buffer and shift the next word into place.
      buf_reg      <= buf_reg << 32;
      word_cnt_reg <= word_cnt_reg + 5'd1;
    end
  end
endmodule

// File: tb/tb_aidc_lite_comp_zrle.sv
// Bench for the ZRLE compressor: directed and random blocks checked against a
// bit-string model built from the code table.
module tb_aidc_lite_comp_zrle;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [63:0] data_i = '0;
  logic        ready_o, valid_o, sop_o, eop_o, done_o, fail_o;
  logic [31:0] data_o;
  logic [4:0]  len_o;
  // Second instance with a tighter limit so the limit comparison can be hit exactly.
  logic        ready_b, valid_b, sop_b, eop_b, done_b, fail_b;
  logic [31:0] data_b;
  logic [4:0]  len_b;

  int checks = 0;
  int failures = 0;

  logic [63:0] blk [8];
  logic [31:0] exp_words [16];
  int          exp_n;
  bit          exp_fail, exp_fail_b;

  string pat_tab [16] = '{"ZZZZ", "ZZZN", "ZZNZ", "ZNZZ", "NZZZ", "ZZNN", "ZNZN", "NZZN",
                          "ZNNZ", "NZNZ", "NNZZ", "ZNNN", "NZNN", "NNZN", "NNNZ", "NNNN"};
  string pfx_tab [16] = '{"000000", "000001", "00001", "00010", "00011", "0010", "0011", "0100",
                          "0101", "0110", "0111", "1000", "1001", "1010", "1011", "11"};

  aidc_lite_comp_zrle dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .sop_o(sop_o), .eop_o(eop_o), .data_o(data_o),
    .done_o(done_o), .fail_o(fail_o), .len_o(len_o)
  );

  aidc_lite_comp_zrle #(.CODE_BUF_SIZE(498)) dut_lim (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_b), .data_i(data_i),
    .valid_o(valid_b), .sop_o(sop_b), .eop_o(eop_b), .data_o(data_b),
    .done_o(done_b), .fail_o(fail_b), .len_o(len_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Build the block's bit stream: "01", then per beat the table prefix and non-zero lanes.
  task automatic model();
    bit q[$];
    string p, s;
    int idx, total;
    logic [15:0] lane;
    q.delete();
    q.push_back(1'b0);
    q.push_back(1'b1);
    for (int b = 0; b < 8; b++) begin
      p = "";
      for (int l = 3; l >= 0; l--) begin
        lane = blk[b][16*l +: 16];
        p = $sformatf("%s%s", p, (lane != 0) ? "N" : "Z");
      end
      idx = 0;
      for (int t = 0; t < 16; t++) if (pat_tab[t] == p) idx = t;
      s = pfx_tab[idx];
      for (int i = 0; i < s.len(); i++) q.push_back(s[i] == 8'h31);
      for (int l = 3; l >= 0; l--) begin
        lane = blk[b][16*l +: 16];
        if (lane != 0) for (int k = 15; k >= 0; k--) q.push_back(lane[k]);
      end
    end
    total = q.size() - 2;
    exp_fail   = (total > 510);
    exp_fail_b = (total > 498);
    exp_n      = exp_fail ? 0 : (total + 2 + 31) / 32;
    for (int w = 0; w < 16; w++)
      for (int b = 0; b < 32; b++)
        exp_words[w][31-b] = (32*w + b < q.size()) ? q[32*w + b] : 1'b0;
  endtask

  task automatic send_block(input bit gaps);
    int i = 0;
    int guard = 0;
    bit first = 1'b1;
    while (i < 8 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (first) begin
        chk("ready_at_start", ready_o, 1);
        first = 1'b0;
      end
      chk("idle_valid_o", valid_o, 0);
      valid_i = (gaps && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      data_i  = valid_i ? blk[i] : {$urandom, $urandom};
      if (valid_i && ready_o) i++;
    end
    if (guard >= 200) chk("send_timeout", i, 8);
  endtask

  task automatic collect(input bit hold, input int stop_at,
                         output logic [31:0] w0, output logic [4:0] last_len);
    int k = 0;
    int cyc = 0;
    bit fin = 1'b0;
    w0 = '0;
    last_len = '0;
    while (!fin && cyc < 20) begin
      @(negedge clk);
      cyc++;
      valid_i = hold;
      data_i  = {$urandom, $urandom};
      chk("busy_ready", ready_o, 0);
      if (k == 0) begin
        chk("lim_fail", fail_b, exp_fail_b);
        chk("lim_valid", valid_b, !exp_fail_b);
      end
      if (exp_fail) begin
        chk("fail_done", done_o, 1);
        chk("fail_flag", fail_o, 1);
        chk("fail_len", len_o, 0);
        chk("fail_valid", valid_o, 0);
        last_len = len_o;
        fin = 1'b1;
      end else begin
        chk("word_valid", valid_o, 1);
        chk($sformatf("word%0d_data", k), data_o, exp_words[k]);
        chk("word_sop", sop_o, k == 0);
        chk("word_eop", eop_o, k == exp_n - 1);
        chk("word_done", done_o, k == exp_n - 1);
        chk("word_len", len_o, (k == exp_n - 1) ? exp_n : 0);
        chk("word_fail", fail_o, 0);
        if (k == 0) w0 = data_o;
        if (k == exp_n - 1) last_len = len_o;
        if (k == stop_at) fin = 1'b1;
        k++;
        if (k == exp_n) fin = 1'b1;
      end
    end
    chk("collect_timeout", fin, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, ready_o, 1);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_sop"}, sop_o, 0);
    chk({tag, "_eop"}, eop_o, 0);
    chk({tag, "_data"}, data_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_fail"}, fail_o, 0);
    chk({tag, "_len"}, len_o, 0);
  endtask

  task automatic run_block(input string tag, input bit gaps, input bit hold);
    logic [31:0] w0;
    logic [4:0]  ll;
    model();
    send_block(gaps);
    collect(hold, -1, w0, ll);
    $display("%s: words=%0d fail=%0d word0=0x%08h len=%0d", tag, exp_n, exp_fail, w0, ll);
  endtask

  initial begin
    logic [31:0] w0;
    logic [4:0]  ll;
    int d;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Test 1: all-zero block
    for (int b = 0; b < 8; b++) blk[b] = '0;
    model();
    send_block(1'b0);
    collect(1'b0, -1, w0, ll);
    chk("t1_word0", w0, 32'h4000_0000);
    chk("t1_len", ll, 2);
    $display("t1: word0=0x%08h len=%0d", w0, ll);

    // Test 2: single ZZZN beat
    blk[0] = 64'h0000_0000_0000_ABCD;
    model();
    send_block(1'b0);
    collect(1'b0, -1, w0, ll);
    chk("t2_word0", w0, 32'h41AB_CD00);
    chk("t2_len", ll, 3);
    $display("t2: word0=0x%08h len=%0d", w0, ll);

    // Test 3: 498 bits, sixteen words
    for (int b = 0; b < 7; b++) blk[b] = 64'h0001_0001_0001_0001;
    blk[7] = 64'h0000_0000_0001_0001;
    model();
    send_block(1'b0);
    collect(1'b0, -1, w0, ll);
    chk("t3_len", ll, 16);
    $display("t3: word0=0x%08h len=%0d", w0, ll);

    // Test 4: 514 bits, incompressible
    blk[7] = 64'h0000_0001_0001_0001;
    model();
    send_block(1'b0);
    collect(1'b0, -1, w0, ll);
    $display("t4: fail=%0d len=%0d", exp_fail, ll);

    // Test 5: reset in the middle of emitting test 3's block
    blk[7] = 64'h0000_0000_0001_0001;
    model();
    send_block(1'b0);
    collect(1'b0, 5, w0, ll);
    rst_n   = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    rst_n = 1'b1;
    for (int b = 0; b < 8; b++) blk[b] = '0;
    model();
    send_block(1'b0);
    collect(1'b0, -1, w0, ll);
    chk("t5_word0", w0, 32'h4000_0000);
    chk("t5_len", ll, 2);
    $display("t5: word0=0x%08h len=%0d", w0, ll);

    // Test 6 and random: blocks back-to-back with valid_i held high while busy
    for (int n = 0; n < 24; n++) begin
      d = $urandom_range(0, 4);
      for (int b = 0; b < 8; b++)
        for (int l = 0; l < 4; l++)
          blk[b][16*l +: 16] = ($urandom_range(0, 3) < d) ? 16'($urandom_range(1, 65535)) : 16'h0;
      run_block($sformatf("rnd%0d", n), (n >= 4) && ($urandom_range(0, 1) == 1),
                (n < 4) || ($urandom_range(0, 1) == 1));
    end

    valid_i = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
